// File: rtl/bmem_pkg.sv
// Shared burst-memory constants and the adapter FSM state type.
// Imported by the cache-line adapter and by any memory model driving it.
`timescale 1ns/1ps
package bmem_pkg;
  localparam int LINE_W    = 256;
  localparam int BEAT_W    = 64;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = $clog2(BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_DONE     = 2'd3
  } state_e;
endpackage

// File: rtl/cacheline_adapter.sv
// Converts 256-bit cache line reads/writebacks into 4-beat 64-bit bursts.
// Build option CACHELINE_ADAPTER_FAST_RESP_EN: completes in the 4th-beat cycle (no DONE state).
//
// state       | meaning
// ST_IDLE     | sample line_write / line_read each cycle (write wins)
// ST_RD_BURST | bmem_read held, one beat stored per bmem_resp
// ST_WR_BURST | bmem_write held, bmem_wdata = latched beat[cnt]
// ST_DONE     | one-cycle line_resp, strobes low (absent in fast build)
`timescale 1ns/1ps
module cacheline_adapter
  import bmem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [LINE_W-1:0] line_wdata,
  output logic [LINE_W-1:0] line_rdata,
  output logic              line_resp,
  output logic [ADDR_W-1:0] bmem_address,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_resp
);

  typedef logic [BURST_LEN-1:0][BEAT_W-1:0] line_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  line_t             wbuf_q, wbuf_d;
  line_t             asm_q, asm_d;
  line_t             rdata_q, rdata_d;
  logic              last_beat;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^line_addr[4:0];
  assign last_beat = bmem_resp && (cnt_q == CNT_W'(BURST_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wbuf_q  <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wbuf_q  <= wbuf_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wbuf_d  = wbuf_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (line_write || line_read) begin
          state_d = line_write ? ST_WR_BURST : ST_RD_BURST;
          wr_d    = line_write;
          rd_d    = !line_write;
          addr_d  = {line_addr[ADDR_W-1:5], 5'b0};
          cnt_d   = '0;
          wbuf_d  = line_wdata;
        end
      end
      ST_RD_BURST, ST_WR_BURST: begin
        if (bmem_resp) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (state_q == ST_RD_BURST) asm_d[cnt_q] = bmem_rdata;
          if (last_beat) begin
            rd_d = 1'b0;
            wr_d = 1'b0;
            // Only a completed read replaces the visible line.
            if (state_q == ST_RD_BURST) rdata_d = asm_d;
`ifdef CACHELINE_ADAPTER_FAST_RESP_EN
            state_d = ST_IDLE;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bmem_address = addr_q;
  assign bmem_read    = rd_q;
  assign bmem_write   = wr_q;
  assign bmem_wdata   = wr_q ? wbuf_q[cnt_q] : '0;

`ifdef CACHELINE_ADAPTER_FAST_RESP_EN
  assign line_resp  = ((state_q == ST_RD_BURST) || (state_q == ST_WR_BURST)) && last_beat;
  // rdata_d carries the freshly assembled line during the final read beat.
  assign line_rdata = rdata_d;
`else
  assign line_resp  = (state_q == ST_DONE);
  assign line_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: line-level memory model, random stalls and resp noise.
`timescale 1ns/1ps
module tb_cacheline_adapter;
  import bmem_pkg::*;

`ifdef CACHELINE_ADAPTER_FAST_RESP_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       line_addr;
  logic              line_read, line_write;
  logic [LINE_W-1:0] line_wdata, line_rdata;
  logic              line_resp;
  logic [31:0]       bmem_address;
  logic              bmem_read, bmem_write;
  logic [BEAT_W-1:0] bmem_wdata, bmem_rdata;
  logic              bmem_resp;

  always #5 clk = ~clk;

  cacheline_adapter #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .line_addr(line_addr), .line_read(line_read), .line_write(line_write),
    .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
    .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
  );

  typedef struct {
    bit          wr;
    logic [255:0] rdata;
    int          lat;
  } exp_t;

  exp_t         exp_q[$];
  logic [255:0] mem [logic [31:0]];
  logic [255:0] shown_rdata;
  logic [255:0] resp_line;
  logic [31:0]  cur_base;
  logic [255:0] cur_wline;
  bit           cur_active, cur_wr, in_reset, resp_seen, rnd_resp, release_pending;
  int           checks = 0, errors = 0, cyc = 0;
  int           beat_n, sample_edge, last_resp_edge, stall_after, stall_left;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_line_resp", line_resp, 0);
    check("rst_bmem_read", bmem_read, 0);
    check("rst_bmem_write", bmem_write, 0);
    check("rst_bmem_address", bmem_address, 0);
    check("rst_bmem_wdata", bmem_wdata, 0);
    check("rst_line_rdata", line_rdata, 0);
  endtask

  // Burst memory: serves/stores whole lines beat by beat, checks strobes every cycle.
  initial begin
    bmem_resp  = 1'b0;
    bmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bmem_resp  = 1'b0;
      bmem_rdata = {$urandom, $urandom};
      if (!in_reset && rst_n) begin
        if (cur_active && cyc >= sample_edge && beat_n < BURST_LEN) begin
          check("strobe_rd", bmem_read, !cur_wr);
          check("strobe_wr", bmem_write, cur_wr);
          check("bmem_address", bmem_address, cur_base);
          if (cur_wr) check("bmem_wdata", bmem_wdata, cur_wline[BEAT_W*beat_n +: BEAT_W]);
          if (beat_n == stall_after && stall_left > 0) begin
            stall_left--;
          end else if (!rnd_resp || $urandom_range(0, 2) != 0) begin
            bmem_resp = 1'b1;
            if (!cur_wr) begin
              resp_line  = mem[cur_base];
              bmem_rdata = resp_line[BEAT_W*beat_n +: BEAT_W];
            end
            beat_n++;
            if (beat_n == BURST_LEN) begin
              last_resp_edge = cyc + 1;
              if (cur_wr) mem[cur_base] = cur_wline;
            end
          end
        end else begin
          check("strobe_idle", {bmem_read, bmem_write}, 2'b00);
          bmem_resp = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: pops one expectation per line_resp cycle; otherwise line_rdata must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !in_reset) begin
        if (line_resp) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_line_resp actual=1 required=0");
          end else begin
            e = exp_q.pop_front();
            check("line_rdata_at_resp", line_rdata, e.rdata);
            check("resp_cycle", cyc, FAST ? last_resp_edge - 1 : last_resp_edge);
            check("beats_at_resp", beat_n, BURST_LEN);
            if (e.lat >= 0) check("latency", cyc - sample_edge + 1, e.lat);
            shown_rdata = e.rdata;
          end
          resp_seen = 1'b1;
        end else begin
          check("line_rdata_hold", line_rdata, shown_rdata);
        end
      end
    end
  end

  task automatic start_txn(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [255:0] wdata, input int st_after, input int st_cnt,
                           input bit rnd);
    exp_t e;
    @(posedge clk);
    #1;
    if (release_pending) begin
      rst_n = 1'b1;
      release_pending = 1'b0;
      in_reset = 1'b0;
    end
    cur_base = {addr[31:5], 5'b0};
    if (!mem.exists(cur_base)) mem[cur_base] = rand_line();
    cur_wr      = wr;
    cur_wline   = wdata;
    beat_n      = 0;
    stall_after = st_after;
    stall_left  = st_cnt;
    rnd_resp    = rnd;
    sample_edge = cyc + 1;
    resp_seen   = 1'b0;
    e.wr    = wr;
    e.rdata = wr ? shown_rdata : mem[cur_base];
    e.lat   = rnd ? -1 : ((FAST ? 4 : 5) + ((st_after >= 0) ? st_cnt : 0));
    exp_q.push_back(e);
    line_addr  = addr;
    line_read  = rd;
    line_write = wr;
    line_wdata = wdata;
    cur_active = 1'b1;
  endtask

  task automatic finish_txn();
    int n = 0;
    while (!resp_seen && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (!resp_seen) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout actual=no_line_resp required=line_resp");
      exp_q.delete();
    end
    #1;
    line_read  = 1'b0;
    line_write = 1'b0;
    cur_active = 1'b0;
    line_wdata = rand_line();
    line_addr  = $urandom;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [255:0] wdata, input int st_after, input int st_cnt,
                        input bit rnd);
    start_txn(wr, rd, addr, wdata, st_after, st_cnt, rnd);
    finish_txn();
  endtask

  initial begin
    logic [31:0] a;
    bit          w, r;
    int          n;
    line_read = 1'b0; line_write = 1'b0; line_addr = '0; line_wdata = '0;
    in_reset = 1'b1; cur_active = 1'b0; beat_n = BURST_LEN; stall_after = -1; stall_left = 0;
    sample_edge = 0; last_resp_edge = 0; resp_seen = 1'b0; rnd_resp = 1'b0;
    shown_rdata = '0; release_pending = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3 check_reset_outputs();
    repeat (2) @(posedge clk);
    release_pending = 1'b1;

    mem[32'h0000_1220] = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_txn(1'b0, 1'b1, 32'h0000_1234, rand_line(), -1, 0, 1'b0);
    do_txn(1'b1, 1'b0, 32'h8000_0040,
           {64'hD3D3_0003_A5A5_3333, 64'hD2D2_0002_5A5A_2222,
            64'hD1D1_0001_C3C3_1111, 64'hD0D0_0000_3C3C_0000}, -1, 0, 1'b0);
    do_txn(1'b0, 1'b1, 32'h8000_0040, rand_line(), 1, 2, 1'b0);
    do_txn(1'b1, 1'b1, 32'h0000_2000, rand_line(), -1, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      a = 32'h4000_0000 | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31);
      do_txn(w, r, a, rand_line(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end

    // Reset in the middle of a read, after two beats have been accepted.
    start_txn(1'b0, 1'b1, 32'h0000_3000, rand_line(), 2, 6, 1'b0);
    n = 0;
    while (beat_n < 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #3;
    shown_rdata = '0;
    in_reset = 1'b1;
    rst_n = 1'b0;
    #1 check_reset_outputs();
    exp_q.delete();
    cur_active = 1'b0;
    line_read = 1'b0;
    repeat (2) @(posedge clk);
    release_pending = 1'b1;
    mem[32'h0000_3000] = rand_line();
    do_txn(1'b0, 1'b1, 32'h0000_3010, rand_line(), -1, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
